// File: rtl/recon_pkg.sv
// rtl/recon_pkg.sv - shared types for the reconstruction datapath
package recon_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic {
    IDLE,
    STREAM
  } in_state_t;

endpackage

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - first-word-fall-through FIFO with registered storage
module stream_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             wr_en;
  logic             rd_en;

  // Guard against overflow/underflow so callers cannot corrupt the pointers.
  assign wr_en    = push & ~full;
  assign rd_en    = pop & ~empty;
  assign full     = (cnt == CNT_W'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/input_ctrl.sv
// rtl/input_ctrl.sv - ingress stage: buffers samples and cuts them into frames
module input_ctrl
  import recon_pkg::*;
#(
  parameter int DATA_W     = SAMPLE_W,
  parameter int FIFO_DEPTH = 8,
  parameter int FRAME_LEN  = 1024,
  parameter int IDX_W      = $clog2(FRAME_LEN)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              iter_busy,
  output logic              iter_new_signal,
  output logic [DATA_W-1:0] proc_data,
  output logic              proc_valid,
  input  logic              proc_ready,
  output logic              proc_last,
  output logic [IDX_W-1:0]  sample_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  in_state_t                     state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic                          new_q, new_d;
  logic                          run_q;
  logic                          push;
  logic                          pop;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic [$clog2(FIFO_DEPTH+1)-1:0] unused_count;

  stream_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .pop_data  (proc_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (unused_count)
  );

  // Keeps in_ready low during reset and for the release edge itself.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  assign in_ready        = run_q & ~fifo_full;
  assign push            = in_valid & in_ready;
  assign proc_valid      = ~fifo_empty & ((state_q == STREAM) | ~iter_busy);
  assign pop             = proc_valid & proc_ready;
  assign proc_last       = proc_valid & (idx_q == LAST_IDX);
  assign sample_idx      = idx_q;
  assign iter_new_signal = new_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      new_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      new_q   <= new_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    new_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = STREAM;
          idx_d   = IDX_W'(1);
          new_d   = 1'b1;
        end
      end
      STREAM: begin
        if (pop) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

endmodule
